// File: rtl/icache_fill_ctrl_pkg.sv
// Shared icache geometry, FSM state encoding and status-bit constants for the fill controller.
// Status slot layout per way is {valid, mru}.
package icache_fill_ctrl_pkg;

  localparam int SET_BITS_WIDTH  = 4;
  localparam int NUM_WAYS        = 4;
  localparam int TAG_WIDTH       = 8;
  localparam int SA_BITS_PER_WAY = 2;
  localparam int TA_WORD_WIDTH   = TAG_WIDTH * NUM_WAYS;
  localparam int SA_WORD_WIDTH   = SA_BITS_PER_WAY * NUM_WAYS;

  localparam logic [SA_BITS_PER_WAY-1:0] SA_VALID = 2'b10;
  localparam logic [SA_BITS_PER_WAY-1:0] SA_MRU   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [TA_WORD_WIDTH-1:0] replicate_tag(input logic [TAG_WIDTH-1:0] tag);
    return {NUM_WAYS{tag}};
  endfunction

  function automatic logic [SA_WORD_WIDTH-1:0] fill_status();
    return {NUM_WAYS{SA_VALID | SA_MRU}};
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_flush_walker.sv
// Set counter for the flush walk: cleared on flush entry, advances per accepted write, wraps after the last set.
// Single-cycle update; the caller gates advance/clear with halt and array ready.
module icache_flush_walker
  import icache_fill_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [SET_BITS_WIDTH-1:0] set_next,
  output logic                      last
);

  logic [SET_BITS_WIDTH-1:0] set_idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      set_idx <= '0;
    end else if (advance) begin
      set_idx <= set_next;
    end
  end

  // Natural wrap of the counter returns it to set 0 after the last set.
  assign set_next = set_idx + 1'b1;
  assign last     = &set_idx;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Refill/flush sequencer and sole writer of the icache tag/status arrays; all outputs registered except o_miss_ready.
// Strobes hold until i_array_ready; i_halt freezes every register.
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_halt,
  input  logic [SET_BITS_WIDTH-1:0]           i_miss_set_addr,
  input  logic [TAG_WIDTH-1:0]                i_miss_tag,
  input  logic [NUM_WAYS-1:0]                 i_miss_way,
  input  logic                                i_miss_valid,
  output logic                                o_miss_ready,
  input  logic                                i_flush_valid,
  output logic [SET_BITS_WIDTH+TAG_WIDTH-1:0] o_mem_req_addr,
  output logic                                o_mem_req_valid,
  input  logic                                i_mem_req_ready,
  input  logic                                i_mem_resp_valid,
  output logic [SET_BITS_WIDTH-1:0]           o_w_set_addr,
  output logic [TA_WORD_WIDTH-1:0]            o_w_ta_data,
  output logic [NUM_WAYS-1:0]                 o_w_ta_mask,
  output logic                                o_w_ta_valid,
  output logic [SA_WORD_WIDTH-1:0]            o_w_sa_data,
  output logic [NUM_WAYS-1:0]                 o_w_sa_mask,
  output logic                                o_w_sa_valid,
  input  logic                                i_array_ready,
  output logic                                o_busy,
  output logic                                o_fill_done
);

  state_t                    state;
  logic                      flush_pending;
  logic [SET_BITS_WIDTH-1:0] miss_set;
  logic [TAG_WIDTH-1:0]      miss_tag;
  logic [NUM_WAYS-1:0]       miss_way;
  logic                      flush_req;
  logic [SET_BITS_WIDTH-1:0] walk_next;
  logic                      walk_last;

  assign flush_req    = flush_pending | i_flush_valid;
  assign o_miss_ready = (state == ST_IDLE) && !flush_req;

  icache_flush_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .clear    (!i_halt && (state == ST_IDLE) && flush_req),
    .advance  (!i_halt && (state == ST_FLUSH) && i_array_ready),
    .set_next (walk_next),
    .last     (walk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      flush_pending   <= 1'b0;
      miss_set        <= '0;
      miss_tag        <= '0;
      miss_way        <= '0;
      o_mem_req_addr  <= '0;
      o_mem_req_valid <= 1'b0;
      o_w_set_addr    <= '0;
      o_w_ta_data     <= '0;
      o_w_ta_mask     <= '0;
      o_w_ta_valid    <= 1'b0;
      o_w_sa_data     <= '0;
      o_w_sa_mask     <= '0;
      o_w_sa_valid    <= 1'b0;
      o_busy          <= 1'b0;
      o_fill_done     <= 1'b0;
    end else if (!i_halt) begin
      // A flush seen mid-refill is remembered; one seen during FLUSH is absorbed.
      if ((state inside {ST_MEM_REQ, ST_MEM_WAIT, ST_WRITE, ST_DONE}) && i_flush_valid) begin
        flush_pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state         <= ST_FLUSH;
            flush_pending <= 1'b0;
            o_busy        <= 1'b1;
            o_w_set_addr  <= '0;
            o_w_sa_data   <= '0;
            o_w_sa_mask   <= '1;
            o_w_sa_valid  <= 1'b1;
          end else if (i_miss_valid) begin
            state           <= ST_MEM_REQ;
            miss_set        <= i_miss_set_addr;
            miss_tag        <= i_miss_tag;
            miss_way        <= i_miss_way;
            o_busy          <= 1'b1;
            o_mem_req_addr  <= {i_miss_tag, i_miss_set_addr};
            o_mem_req_valid <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (i_array_ready) begin
            if (walk_last) begin
              state        <= ST_IDLE;
              o_busy       <= 1'b0;
              o_w_sa_valid <= 1'b0;
              o_w_set_addr <= '0;
            end else begin
              o_w_set_addr <= walk_next;
            end
          end
        end
        ST_MEM_REQ: begin
          if (i_mem_req_ready) begin
            state           <= ST_MEM_WAIT;
            o_mem_req_valid <= 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_resp_valid) begin
            state        <= ST_WRITE;
            o_w_set_addr <= miss_set;
            o_w_ta_data  <= replicate_tag(miss_tag);
            o_w_ta_mask  <= miss_way;
            o_w_ta_valid <= 1'b1;
            o_w_sa_data  <= fill_status();
            o_w_sa_mask  <= miss_way;
            o_w_sa_valid <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (i_array_ready) begin
            state        <= ST_DONE;
            o_w_ta_valid <= 1'b0;
            o_w_sa_valid <= 1'b0;
            o_fill_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          o_busy      <= 1'b0;
          o_fill_done <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Sequences instruction-cache line refills and cache flushes for the tag/status lookup stage.
- On a miss reported by the compare stage, it issues one memory line request and waits for the response. It then writes the new tag into the victim way of the tag array and marks that way valid in the status array.
- On a flush request, it walks every set and clears all status bits.
- It is the only source of tag/status array write ports. Read lookups are blocked while it is busy.

Parameters:
- SET_BITS_WIDTH, 4, set index width (16 sets)
- NUM_WAYS, 4, associativity; also the write-mask width
- TAG_WIDTH, 8, tag bits per way; TA_WORD_WIDTH = TAG_WIDTH*NUM_WAYS
- SA_BITS_PER_WAY, 2, status bits per way {valid, mru}; SA_WORD_WIDTH = SA_BITS_PER_WAY*NUM_WAYS

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_halt  in  1  pipeline halt; freezes FSM, counters and all outputs
- i_miss_set_addr  in  SET_BITS_WIDTH  set of missing fetch
- i_miss_tag  in  TAG_WIDTH  tag of missing fetch
- i_miss_way  in  NUM_WAYS  one-hot victim way
- i_miss_valid  in  1  miss request
- o_miss_ready  out  1  miss accepted when valid&ready&~halt
- i_flush_valid  in  1  flush request (level or pulse)
- o_mem_req_addr  out  SET_BITS_WIDTH+TAG_WIDTH  {tag,set} line address
- o_mem_req_valid  out  1  memory request
- i_mem_req_ready  in  1  memory accepts request
- i_mem_resp_valid  in  1  line data returned (data written elsewhere)
- o_w_set_addr  out  SET_BITS_WIDTH  shared tag/status write set
- o_w_ta_data  out  TA_WORD_WIDTH  tag replicated into every way slot
- o_w_ta_mask  out  NUM_WAYS  tag write mask
- o_w_ta_valid  out  1  tag write strobe
- o_w_sa_data  out  SA_WORD_WIDTH  status write data
- o_w_sa_mask  out  NUM_WAYS  status write mask
- o_w_sa_valid  out  1  status write strobe
- i_array_ready  in  1  arrays' combined ready
- o_busy  out  1  controller not IDLE; gates lookup reads upstream
- o_fill_done  out  1  one-cycle pulse when a refill completes

Behaviour:
- Reset: state IDLE, flush-pending=0, set counter=0. All outputs 0 except o_miss_ready=1.
- States: IDLE, FLUSH, MEM_REQ, MEM_WAIT, WRITE, DONE. When i_halt=1, no state, counter or register changes, and outputs hold their values.
- IDLE:
  - If flush-pending or i_flush_valid, go to FLUSH with counter=0. Flush has priority over a simultaneous miss; o_miss_ready=0 that cycle.
  - Else, if the miss handshake occurs, latch set/tag/way and go to MEM_REQ.
  - o_miss_ready=1 only in IDLE with no flush request present.
- MEM_REQ: o_mem_req_valid=1 with the latched {tag,set}. When i_mem_req_ready=1, go to MEM_WAIT.
- MEM_WAIT: wait for i_mem_resp_valid, then go to WRITE. A response arriving in MEM_REQ is ignored.
- WRITE:
  - Tag array write: o_w_ta_valid=1, mask=latched way, data=tag replicated NUM_WAYS times.
  - Status array write: o_w_sa_valid=1, mask=latched way, data=2'b11 per slot.
  - Strobes hold until i_array_ready=1. Both writes complete in that cycle, then go to DONE.
- DONE: o_fill_done=1 for exactly one cycle, then return to IDLE.
- FLUSH:
  - Each cycle, o_w_sa_valid=1, o_w_sa_mask=all ones, o_w_sa_data=0, o_w_set_addr=counter. No tag write.
  - On i_array_ready, the counter increments.
  - After set 2^SET_BITS_WIDTH-1 is accepted, the counter wraps to 0 and the FSM goes to IDLE. A full flush takes 16 accepted cycles.
- Flush during a refill: an i_flush_valid seen in a non-IDLE, non-FLUSH state sets flush-pending. That flush runs right after DONE→IDLE, before any new miss. flush-pending is cleared on entry to FLUSH.
- i_flush_valid asserted during FLUSH is absorbed; there is no second flush.
- Outputs are registered, except o_miss_ready, which is decoded from state.
- o_busy = (state != IDLE).
- Reset mid-operation abandons the request and returns to the reset values. The memory side must tolerate the dropped request.
- Illegal miss way (not one-hot): the mask is written as given, with no checking. Verification asserts one-hot.

Decomposition:
- Shared icache package holds SET_BITS_WIDTH, NUM_WAYS, TAG_WIDTH, SA_BITS_PER_WAY, the derived word widths, the state encoding, and the status-bit constants SA_VALID and SA_MRU.
- One sub-module, icache_flush_walker, holds the set counter with its advance/wrap/last logic. The FSM stays in the top level.

Test Plan:
- Reset check: assert rst for 2 cycles → all outputs 0, o_miss_ready=1, o_busy=0.
- Basic refill: miss set=5, tag=0xA3, way=4'b0100, memory ready immediately, response after 3 cycles.
  - Expected: o_mem_req_addr=0xA35; write with ta_data=0xA3A3A3A3, ta_mask=4'b0100, sa_data=8'hFF, sa_mask=4'b0100.
  - Expected: o_fill_done pulses 1 cycle after i_array_ready.
- Full flush: i_flush_valid pulse in IDLE → 16 status writes, sets 0..15 in order, mask 4'hF, data 0. Returns to IDLE; o_busy low after the last write.
- Simultaneous events:
  - Flush and miss in the same IDLE cycle → flush runs first, the miss is not accepted (o_miss_ready=0) and is accepted after the flush.
  - Flush during MEM_WAIT → refill completes, then the flush starts the cycle after DONE.
- Backpressure/halt:
  - i_array_ready=0 for 4 cycles in WRITE → strobes and data held stable.
  - i_halt=1 mid-FLUSH at set 7 for 3 cycles → counter stays 7, then resumes and finishes at set 15.
- Reset in MEM_WAIT → next cycle in IDLE, o_mem_req_valid=0, and a later i_mem_resp_valid is ignored.
